// File: rtl/uart_word_streamer.sv
// rtl/uart_word_streamer.sv - word FIFO feeding a part-sliced UART transmitter
module uart_word_streamer #(
  parameter int WORD_SIZE    = 32,
  parameter int WORD_PART    = 8,
  parameter int DEPTH        = 64,
  parameter int CLKS_PER_BIT = 1736,
  parameter int MSB_FIRST    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WORD_SIZE-1:0]     data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int PARTS = WORD_SIZE / WORD_PART;
  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int BW    = $clog2(WORD_PART);
  localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1;
  localparam int SW    = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [AW:0]   LEVEL_FULL = DEPTH[AW:0];
  localparam logic [TW-1:0] T_RELOAD   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WORD_PART - 1);
  localparam logic [PW-1:0] LAST_PART  = PW'(PARTS - 1);
  localparam logic [SW-1:0] LAST_STOP  = SW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [WORD_SIZE-1:0]   mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [WORD_SIZE-1:0]   shreg;
  logic [WORD_PART-1:0]   cur_part;
  logic [TW-1:0]          timer;
  logic [BW-1:0]          bit_cnt;
  logic [BW-1:0]          next_bit;
  logic [PW-1:0]          part_cnt;
  logic [SW-1:0]          stop_cnt;
  logic                   wr;
  logic                   pop;
  logic                   bit_end;
  logic                   stop_last;
  logic                   part_last;

  assign full      = (level == LEVEL_FULL);
  assign empty     = (level == '0);
  assign in_ready  = ~full;
  assign wr        = in_valid && !full;
  assign bit_end   = (timer == '0);
  assign stop_last = (stop_cnt == LAST_STOP);
  assign part_last = (part_cnt == LAST_PART);
  assign next_bit  = bit_cnt + 1'b1;

  // The FSM consumes the head word either from idle or at the very end of a word's last stop bit.
  assign pop = !empty && ((state == IDLE) ||
                          (state == STOP && bit_end && stop_last && part_last));

  assign cur_part = (MSB_FIRST != 0) ? shreg[WORD_SIZE-1 -: WORD_PART]
                                     : shreg[WORD_PART-1:0];

  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      timer    <= '0;
      bit_cnt  <= '0;
      part_cnt <= '0;
      stop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            part_cnt <= '0;
            busy     <= 1'b1;
            tx       <= 1'b0;
            timer    <= T_RELOAD;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= cur_part[0];
            timer   <= T_RELOAD;
            state   <= DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= T_RELOAD;
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= '0;
              tx       <= 1'b1;
              state    <= STOP;
            end else begin
              bit_cnt <= next_bit;
              tx      <= cur_part[next_bit];
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= T_RELOAD;
            if (!stop_last) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else if (!part_last) begin
              part_cnt <= part_cnt + 1'b1;
              shreg    <= (MSB_FIRST != 0) ? (shreg << WORD_PART) : (shreg >> WORD_PART);
              tx       <= 1'b0;
              state    <= START;
            end else if (pop) begin
              shreg    <= mem[rd_ptr];
              part_cnt <= '0;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_streamer.sv
// tb/tb_uart_word_streamer.sv - scoreboard bench decoding tx frames of two configurations
module tb_uart_word_streamer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] data_a = '0;
  logic        valid_a = 1'b0;
  logic        in_ready_a, tx_a, full_a, empty_a, busy_a;
  logic [6:0]  level_a;

  logic [31:0] data_b = '0;
  logic        valid_b = 1'b0;
  logic        in_ready_b, tx_b, full_b, empty_b, busy_b;
  logic [3:0]  level_b;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_a[$];
  logic [8:0] rx_a[$];
  logic [8:0] exp_b[$];
  logic [8:0] rx_b[$];

  always #5 clock = ~clock;

  uart_word_streamer #(.WORD_SIZE(32), .WORD_PART(8), .DEPTH(64), .CLKS_PER_BIT(4),
                       .MSB_FIRST(1), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset(reset), .data_in(data_a), .in_valid(valid_a),
    .in_ready(in_ready_a), .tx(tx_a), .full(full_a), .empty(empty_a),
    .level(level_a), .busy(busy_a));

  uart_word_streamer #(.WORD_SIZE(32), .WORD_PART(8), .DEPTH(8), .CLKS_PER_BIT(4),
                       .MSB_FIRST(0), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset(reset), .data_in(data_b), .in_valid(valid_b),
    .in_ready(in_ready_b), .tx(tx_b), .full(full_b), .empty(empty_b),
    .level(level_b), .busy(busy_b));

  // Receivers: sample each bit 1.5 cycles into it, push {stop bits ok, data}.
  int         cnt_a = 0, cnt_b = 0;
  bit         act_a = 0, act_b = 0;
  logic [7:0] sh_a, sh_b;
  logic       st_b;

  always @(negedge clock) begin
    if (reset) begin
      act_a = 0;
      cnt_a = 0;
    end else if (!act_a) begin
      if (tx_a === 1'b0) begin act_a = 1; cnt_a = 0; end
    end else begin
      cnt_a++;
      if (cnt_a % 4 == 1) begin
        if (cnt_a / 4 >= 1 && cnt_a / 4 <= 8) sh_a[cnt_a/4-1] = tx_a;
        else if (cnt_a / 4 == 9) begin rx_a.push_back({tx_a, sh_a}); act_a = 0; end
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      act_b = 0;
      cnt_b = 0;
    end else if (!act_b) begin
      if (tx_b === 1'b0) begin act_b = 1; cnt_b = 0; end
    end else begin
      cnt_b++;
      if (cnt_b % 4 == 1) begin
        if (cnt_b / 4 >= 1 && cnt_b / 4 <= 8) sh_b[cnt_b/4-1] = tx_b;
        else if (cnt_b / 4 == 9) st_b = tx_b;
        else if (cnt_b / 4 == 10) begin rx_b.push_back({st_b & tx_b, sh_b}); act_b = 0; end
      end
    end
  end

  task automatic push_exp_a(input logic [31:0] w);
    for (int p = 0; p < 4; p++) exp_a.push_back({1'b1, w[31-8*p -: 8]});
  endtask

  task automatic push_exp_b(input logic [31:0] w);
    for (int p = 0; p < 4; p++) exp_b.push_back({1'b1, w[8*p +: 8]});
  endtask

  task automatic wait_idle_a(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy_a && empty_a && rx_a.size() >= exp_a.size()) break;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++;
    if ({tx_a, empty_a, full_a, level_a, busy_a, in_ready_a} !== {1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_during: tx=%b empty=%b full=%b level=%0d busy=%b in_ready=%b expected 1 1 0 0 0 1",
               tx_a, empty_a, full_a, level_a, busy_a, in_ready_a);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx_a, empty_a, full_a, level_a, busy_a, in_ready_a} !== {1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_after: tx=%b empty=%b full=%b level=%0d busy=%b in_ready=%b expected 1 1 0 0 0 1",
               tx_a, empty_a, full_a, level_a, busy_a, in_ready_a);
    end
  endtask

  task automatic test_msb_first;
    int n;
    logic [8:0] e, g;
    data_a = 32'hA1B2C3D4; valid_a = 1'b1; push_exp_a(32'hA1B2C3D4);
    @(negedge clock);
    valid_a = 1'b0;
    checks++;
    if (tx_a !== 1'b1 || level_a !== 7'd1) begin
      errors++; $display("FAIL msb_write_edge: tx=%b level=%0d expected tx=1 level=1", tx_a, level_a);
    end
    @(negedge clock);
    checks++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1 || level_a !== 7'd0) begin
      errors++; $display("FAIL msb_start: tx=%b busy=%b level=%0d expected 0 1 0", tx_a, busy_a, level_a);
    end
    n = 0;
    while (busy_a === 1'b1 && n < 2000) begin n++; @(negedge clock); end
    checks++;
    if (n != 160) begin errors++; $display("FAIL msb_busy_cycles: got %0d expected 160", n); end
    checks++;
    if (rx_a.size() != exp_a.size()) begin
      errors++; $display("FAIL msb_frame_count: got %0d expected %0d", rx_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); g = rx_a.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL msb_frame: got %h expected %h", g, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  task automatic test_lsb_first_two_stop;
    int n;
    logic [8:0] e, g;
    data_b = 32'hA1B2C3D4; valid_b = 1'b1; push_exp_b(32'hA1B2C3D4);
    @(negedge clock);
    valid_b = 1'b0;
    @(negedge clock);
    checks++;
    if (tx_b !== 1'b0 || busy_b !== 1'b1) begin
      errors++; $display("FAIL lsb_start: tx=%b busy=%b expected 0 1", tx_b, busy_b);
    end
    n = 0;
    while (busy_b === 1'b1 && n < 2000) begin n++; @(negedge clock); end
    checks++;
    if (n != 176) begin errors++; $display("FAIL lsb_busy_cycles: got %0d expected 176", n); end
    checks++;
    if (rx_b.size() != exp_b.size()) begin
      errors++; $display("FAIL lsb_frame_count: got %0d expected %0d", rx_b.size(), exp_b.size());
    end
    while (exp_b.size() > 0 && rx_b.size() > 0) begin
      e = exp_b.pop_front(); g = rx_b.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL lsb_frame: got %h expected %h", g, e); end
    end
    exp_b.delete(); rx_b.delete();
  endtask

  task automatic test_fill;
    int accepted = 0;
    logic [31:0] w;
    logic [8:0] e, g;
    for (int i = 0; i < 70; i++) begin
      w = $urandom; data_a = w; valid_a = 1'b1;
      if (in_ready_a) begin accepted++; push_exp_a(w); end
      @(negedge clock);
    end
    valid_a = 1'b0;
    checks++;
    if (accepted != 65) begin errors++; $display("FAIL fill_accepted: got %0d expected 65", accepted); end
    checks++;
    if (full_a !== 1'b1 || level_a !== 7'd64 || in_ready_a !== 1'b0) begin
      errors++; $display("FAIL fill_flags: full=%b level=%0d in_ready=%b expected 1 64 0", full_a, level_a, in_ready_a);
    end
    wait_idle_a(12000);
    checks++;
    if (empty_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL fill_drained: empty=%b busy=%b expected 1 0", empty_a, busy_a);
    end
    checks++;
    if (rx_a.size() != exp_a.size()) begin
      errors++; $display("FAIL fill_frame_count: got %0d expected %0d", rx_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); g = rx_a.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL fill_frame: got %h expected %h", g, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  task automatic test_reset_mid_frame;
    logic [8:0] e, g;
    data_a = 32'h11223344; valid_a = 1'b1;
    @(negedge clock);
    valid_a = 1'b0;
    @(negedge clock);
    repeat (57) @(negedge clock);
    checks++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: tx=%b busy=%b expected 0 1", tx_a, busy_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_a !== 1'b1 || level_a !== 7'd0 || busy_a !== 1'b0 || empty_a !== 1'b1) begin
      errors++; $display("FAIL midreset_now: tx=%b level=%0d busy=%b empty=%b expected 1 0 0 1",
                         tx_a, level_a, busy_a, empty_a);
    end
    exp_a.delete(); rx_a.delete(); exp_b.delete(); rx_b.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    data_a = 32'h5A3C96E1; valid_a = 1'b1; push_exp_a(32'h5A3C96E1);
    @(negedge clock);
    valid_a = 1'b0;
    wait_idle_a(1000);
    checks++;
    if (rx_a.size() != exp_a.size()) begin
      errors++; $display("FAIL midreset_frame_count: got %0d expected %0d", rx_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); g = rx_a.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL midreset_frame: got %h expected %h", g, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  task automatic test_same_edge;
    logic [31:0] w;
    logic [8:0] e, g;
    for (int i = 0; i < 6; i++) begin
      w = $urandom; data_a = w; valid_a = 1'b1; push_exp_a(w);
      @(negedge clock);
    end
    valid_a = 1'b0;
    repeat (155) @(negedge clock);
    checks++;
    if (level_a !== 7'd5) begin errors++; $display("FAIL same_edge_before: level=%0d expected 5", level_a); end
    w = $urandom; data_a = w; valid_a = 1'b1; push_exp_a(w);
    @(negedge clock);
    valid_a = 1'b0;
    checks++;
    if (level_a !== 7'd5 || busy_a !== 1'b1) begin
      errors++; $display("FAIL same_edge_after: level=%0d busy=%b expected 5 1", level_a, busy_a);
    end
    wait_idle_a(3000);
    checks++;
    if (rx_a.size() != exp_a.size() || busy_a !== 1'b0) begin
      errors++; $display("FAIL same_edge_frames: got %0d busy=%b expected %0d busy=0", rx_a.size(), busy_a, exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); g = rx_a.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL same_edge_frame: got %h expected %h", g, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  task automatic test_wrap;
    int sent = 0;
    int guard = 0;
    logic [31:0] w;
    logic [8:0] e, g;
    w = $urandom;
    while (sent < 200 && guard < 40000) begin
      valid_a = ($urandom_range(0, 3) != 0); data_a = w;
      if (valid_a && in_ready_a) begin push_exp_a(w); sent++; w = $urandom; end
      @(negedge clock);
      guard++;
    end
    valid_a = 1'b0;
    checks++;
    if (sent != 200) begin errors++; $display("FAIL wrap_sent: got %0d expected 200", sent); end
    wait_idle_a(12000);
    checks++;
    if (rx_a.size() != exp_a.size() || empty_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL wrap_frames: got %0d empty=%b busy=%b expected %0d 1 0",
                         rx_a.size(), empty_a, busy_a, exp_a.size());
    end
    while (exp_a.size() > 0 && rx_a.size() > 0) begin
      e = exp_a.pop_front(); g = rx_a.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_frame: got %h expected %h", g, e); end
    end
    exp_a.delete(); rx_a.delete();
  endtask

  initial begin
    test_reset;
    test_msb_first;
    test_lsb_first_two_stop;
    repeat (5) @(negedge clock);
    test_fill;
    repeat (5) @(negedge clock);
    test_reset_mid_frame;
    repeat (5) @(negedge clock);
    test_same_edge;
    repeat (5) @(negedge clock);
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
